// File: rtl/imm_splitter_pkg.sv
// Shared encodings for the immediate splitter and the decode-side sign-extension stage.
package imm_splitter_pkg;

  typedef enum logic [1:0] {
    KIND_SEXT  = 2'd0,
    KIND_UPPER = 2'd1,
    KIND_LOWER = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_EMIT_SINGLE = 2'd1,
    ST_EMIT_UPPER  = 2'd2,
    ST_EMIT_LOWER  = 2'd3
  } state_e;

endpackage

// File: rtl/imm_fit_check.sv
// True when a 32-bit constant is representable as a sign-extended 16-bit immediate.
module imm_fit_check (
  input  logic [31:0] value,
  output logic        fits
);

  assign fits = (value[31:15] == '0) || (value[31:15] == '1);

endmodule

// File: rtl/imm_splitter.sv
// Splits 32-bit constants into SEXT, or LUI + optional ORI, halfword fields.
// Statistics counters are built only when IMM_SPLITTER_STATS_EN is defined.
module imm_splitter
  import imm_splitter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_half,
  output logic [1:0]       out_kind,
  output logic             out_last,
  output logic [CNT_W-1:0] stat_single,
  output logic [CNT_W-1:0] stat_pair
);

  state_e      state_q;
  kind_e       kind_q;
  logic [15:0] half_q;
  logic [15:0] lo_q;
  logic        last_q;
  logic        fits;
  logic        accept;
  logic        out_xfer;

  imm_fit_check u_fit (
    .value (in_data),
    .fits  (fits)
  );

  assign out_valid = (state_q != ST_IDLE);
  assign out_xfer  = out_valid && out_ready;
  // Taking the last halfword frees the slot in the same cycle, so streams run without bubbles.
  assign in_ready  = (state_q == ST_IDLE) || (out_xfer && last_q);
  assign accept    = in_valid && in_ready;

  assign out_half  = half_q;
  assign out_kind  = kind_q;
  assign out_last  = last_q;

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      kind_q  <= KIND_SEXT;
      last_q  <= 1'b0;
    end else if (accept) begin
      if (fits) begin
        state_q <= ST_EMIT_SINGLE;
        half_q  <= in_data[15:0];
        kind_q  <= KIND_SEXT;
        last_q  <= 1'b1;
      end else begin
        state_q <= ST_EMIT_UPPER;
        half_q  <= in_data[31:16];
        kind_q  <= KIND_UPPER;
        last_q  <= (in_data[15:0] == '0);
      end
    end else if (out_xfer) begin
      if (last_q) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= ST_EMIT_LOWER;
        half_q  <= lo_q;
        kind_q  <= KIND_LOWER;
        last_q  <= 1'b1;
      end
    end
  end

  // NOTE: lo_q has no reset; it is always written on acceptance before EMIT_LOWER can read it.
  always_ff @(posedge clk) begin
    if (accept) lo_q <= in_data[15:0];
  end

`ifdef IMM_SPLITTER_STATS_EN
  logic [CNT_W-1:0] single_q;
  logic [CNT_W-1:0] pair_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      single_q <= '0;
      pair_q   <= '0;
    end else begin
      if (out_xfer && state_q == ST_EMIT_SINGLE) single_q <= single_q + 1'b1;
      if (out_xfer && state_q == ST_EMIT_UPPER)  pair_q   <= pair_q + 1'b1;
    end
  end

  assign stat_single = single_q;
  assign stat_pair   = pair_q;
`else
  assign stat_single = '0;
  assign stat_pair   = '0;
`endif

endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: directed scenarios plus a random stream against a queue model.
module tb_imm_splitter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_half;
  logic [1:0]       out_kind;
  logic             out_last;
  logic [CNT_W-1:0] stat_single;
  logic [CNT_W-1:0] stat_pair;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] half;
    logic [1:0]  kind;
    logic        last;
  } hw_t;

  hw_t              exp_q[$];
  logic [CNT_W-1:0] exp_single = '0;
  logic [CNT_W-1:0] exp_pair   = '0;

  imm_splitter #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_half    (out_half),
    .out_kind    (out_kind),
    .out_last    (out_last),
    .stat_single (stat_single),
    .stat_pair   (stat_pair)
  );

  always #5 clk = ~clk;

  // Reference: a constant that lies in the signed 16-bit range is one SEXT field;
  // otherwise LUI of the high half, plus ORI of the low half when it is non-zero.
  function automatic void expand(input logic [31:0] v);
    int sv;
    sv = $signed(v);
    if (sv >= -32768 && sv <= 32767) begin
      exp_q.push_back('{half: v[15:0], kind: 2'd0, last: 1'b1});
    end else if (v[15:0] == 16'h0000) begin
      exp_q.push_back('{half: v[31:16], kind: 2'd1, last: 1'b1});
    end else begin
      exp_q.push_back('{half: v[31:16], kind: 2'd1, last: 1'b0});
      exp_q.push_back('{half: v[15:0],  kind: 2'd2, last: 1'b1});
    end
  endfunction

  task automatic check_stats(input string tag);
    logic [CNT_W-1:0] want_s, want_p;
`ifdef IMM_SPLITTER_STATS_EN
    want_s = exp_single;
    want_p = exp_pair;
`else
    want_s = '0;
    want_p = '0;
`endif
    checks++;
    if (stat_single !== want_s) begin
      errors++;
      $display("FAIL %s stat_single: got %0d want %0d", tag, stat_single, want_s);
    end
    checks++;
    if (stat_pair !== want_p) begin
      errors++;
      $display("FAIL %s stat_pair: got %0d want %0d", tag, stat_pair, want_p);
    end
  endtask

  // Streams constants through the DUT; ready_mode 0=always ready, 1=random valid/ready,
  // 2=out_ready low for cycles 1..5. Entered and left at one time unit after a rising edge.
  task automatic run(input string tag, input logic [31:0] vals[$], input int ready_mode,
                     output int cycles);
    int  idx = 0;
    int  cyc = 0;
    bit  model_ready, acc, outx;
    while ((idx < vals.size() || exp_q.size() != 0) && cyc < 2000) begin
      in_valid  = (idx < vals.size()) && (ready_mode != 1 || $urandom_range(0, 3) != 0);
      in_data   = in_valid ? vals[idx] : $urandom;
      out_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) :
                  !(cyc >= 1 && cyc <= 5);
      #1;
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL %s out_valid cyc%0d: got %b want %b", tag, cyc, out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({out_half, out_kind, out_last} !== exp_q[0]) begin
          errors++;
          $display("FAIL %s halfword cyc%0d: got %h/%0d/%b want %h/%0d/%b", tag, cyc,
                   out_half, out_kind, out_last, exp_q[0].half, exp_q[0].kind, exp_q[0].last);
        end
      end
      model_ready = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
      checks++;
      if (in_ready !== model_ready) begin
        errors++;
        $display("FAIL %s in_ready cyc%0d: got %b want %b", tag, cyc, in_ready, model_ready);
      end
      check_stats(tag);
      acc  = in_valid && model_ready;
      outx = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      #1;
      if (outx) begin
        if (exp_q[0].kind == 2'd0) exp_single++;
        if (exp_q[0].kind == 2'd1) exp_pair++;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        expand(vals[idx]);
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles want under 2000", tag, cyc);
    end
    check_stats({tag, "_end"});
    cycles = cyc;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out_half, out_kind, out_last} !== 20'h0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b h=%h k=%0d l=%b want all 0",
               out_valid, out_half, out_kind, out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
    check_stats("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_sext();
    logic [31:0] v[$];
    int cyc;
    v = '{32'h0000_1234, 32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_0000};
    run("sext", v, 0, cyc);
  endtask

  task automatic test_pair();
    logic [31:0] v[$];
    int cyc;
    v = '{32'h1234_5678, 32'h0000_8000};
    run("pair", v, 0, cyc);
  endtask

  task automatic test_upper_only();
    logic [31:0] v[$];
    int cyc;
    v = '{32'hABCD_0000, 32'h8000_0000};
    run("upper", v, 0, cyc);
  endtask

  task automatic test_stall();
    logic [31:0] v[$];
    int cyc;
    v = '{32'h1234_5678};
    run("stall", v, 2, cyc);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL stall cycles: got %0d want 8", cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v[$];
    int cyc;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_half, out_kind, out_last} !== {1'b1, 16'h5678, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL rstmid lower: got v=%b h=%h k=%0d l=%b want 1/5678/2/1",
               out_valid, out_half, out_kind, out_last);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_single = '0;
    exp_pair   = '0;
    checks++;
    if ({out_valid, out_half, out_kind, out_last} !== 20'h0) begin
      errors++;
      $display("FAIL rstmid async: got v=%b h=%h k=%0d l=%b want all 0",
               out_valid, out_half, out_kind, out_last);
    end
    check_stats("rstmid");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid residual: got out_valid %b want 0", out_valid);
    end
    v = '{32'hFFFF_8000};
    run("rstmid_after", v, 0, cyc);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v[$];
    int cyc;
    v = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000};
    run("b2b", v, 0, cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL b2b cycles: got %0d want 5", cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] v[$];
    int cyc;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       v.push_back({{16{1'($urandom_range(0, 1))}}, 16'($urandom)});
        1:       v.push_back({16'($urandom), 16'h0000});
        default: v.push_back($urandom);
      endcase
    end
    run("random", v, 1, cyc);
  endtask

  initial begin
    test_reset();
    test_sext();
    test_pair();
    test_upper_only();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
